// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation encodings, the
// handshake FSM state type and the signed-overflow helper.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_MUL = 3'd3;
  localparam logic [2:0] ALU_DIV = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  // Two's-complement add overflow: operands agree in sign, result does not.
  // For subtraction the caller passes the inverted sign of B.
  function automatic logic signed_overflow(input logic sign_a,
                                           input logic sign_b,
                                           input logic sign_r);
    return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) core.
// Works on magnitudes only, one bit per cycle for WIDTH cycles; the
// caller handles signs. done is high during the final iteration, so the
// outputs hold the finished values from the following cycle onward.
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy;
  logic             div_mode;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] operand;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  // One iteration step: conditional add then shift right for multiply,
  // shift left then trial subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, operand});
    hi_next   = hi;
    lo_next   = lo;
    if (div_mode) begin
      hi_next = div_fits ? (div_shift[WIDTH-1:0] - operand) : div_shift[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], div_fits};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Load operands on start, then step until the counter runs out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      div_mode <= 1'b0;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      operand  <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      div_mode <= is_div;
      count    <= CNT_W'(WIDTH - 1);
      hi       <= '0;
      lo       <= is_div ? a_mag : b_mag;
      operand  <= is_div ? b_mag : a_mag;
    end else if (busy) begin
      hi <= hi_next;
      lo <= lo_next;
      if (count == '0) begin
        busy <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign done      = busy && (count == '0);
  assign prod_hi   = hi;
  assign prod_lo   = lo;
  assign quotient  = lo;
  assign remainder = hi;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready issue and result handshakes.
// Single-cycle ops finish on the accept edge; signed MUL/DIV go through
// the iterative seq_muldiv core and a sign-fix cycle.
// Optional feature macro: SEQ_ALU_REM_EN adds the signed remainder port rem.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
`ifdef SEQ_ALU_REM_EN
  ,
  output logic [WIDTH-1:0] rem
`endif
);

  import alu_pkg::*;

  state_t state;
  state_t state_n;

  logic             accept;
  logic             start;
  logic             load;
  logic [WIDTH-1:0] result_n;
  logic             ovf_n;
  logic             dbz_n;

  logic             is_div;
  logic             neg;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               md_done;
  logic [WIDTH-1:0]   prod_hi;
  logic [WIDTH-1:0]   prod_lo;
  logic [WIDTH-1:0]   quot_mag;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic               mul_ovf;

`ifdef SEQ_ALU_REM_EN
  logic             rem_neg;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] rem_n;
`endif

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign out_valid = (state == S_DONE);

  assign sum   = a + b;
  assign diff  = a - b;
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .is_div   (alu_op == ALU_DIV),
    .a_mag    (abs_a),
    .b_mag    (abs_b),
    .done     (md_done),
    .prod_hi  (prod_hi),
    .prod_lo  (prod_lo),
    .quotient (quot_mag),
`ifdef SEQ_ALU_REM_EN
    .remainder(rem_mag)
`else
    .remainder()
`endif
  );

  // Sign fix for the iterative ops; a positive quotient with its top bit
  // set can only come from most-negative / -1, which is the DIV overflow.
  always_comb begin
    prod_s  = neg ? -{prod_hi, prod_lo} : {prod_hi, prod_lo};
    quot_s  = neg ? -quot_mag : quot_mag;
    mul_ovf = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
  end

`ifdef SEQ_ALU_REM_EN
  // Remainder takes the sign of the dividend.
  always_comb begin
    rem_s = rem_neg ? -rem_mag : rem_mag;
  end
`endif

  // Handshake FSM next state plus the value to register as the new result.
  always_comb begin
    state_n  = state;
    start    = 1'b0;
    load     = 1'b0;
    result_n = '0;
    ovf_n    = 1'b0;
    dbz_n    = 1'b0;
`ifdef SEQ_ALU_REM_EN
    rem_n    = '0;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if ((state == S_DONE) && out_ready) begin
          state_n = S_IDLE;
        end
        if (accept) begin
          state_n = S_DONE;
          load    = 1'b1;
          case (alu_op)
            ALU_AND: result_n = a & b;
            ALU_OR:  result_n = a | b;
            ALU_ADD: begin
              result_n = sum;
              ovf_n    = signed_overflow(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
            end
            ALU_SUB: begin
              result_n = diff;
              ovf_n    = signed_overflow(a[WIDTH-1], ~b[WIDTH-1], diff[WIDTH-1]);
            end
            ALU_SLL: result_n = b << a[SHAMT_W-1:0];
            ALU_MUL: begin
              load    = 1'b0;
              start   = 1'b1;
              state_n = S_CALC;
            end
            ALU_DIV: begin
              if (b == '0) begin
                result_n = '1;
                dbz_n    = 1'b1;
`ifdef SEQ_ALU_REM_EN
                rem_n    = a;
`endif
              end else begin
                load    = 1'b0;
                start   = 1'b1;
                state_n = S_CALC;
              end
            end
            default: result_n = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          endcase
        end
      end
      S_CALC: begin
        if (md_done) begin
          state_n = S_FIX;
        end
      end
      S_FIX: begin
        state_n = S_DONE;
        load    = 1'b1;
        if (is_div) begin
          result_n = quot_s;
          ovf_n    = !neg && quot_mag[WIDTH-1];
`ifdef SEQ_ALU_REM_EN
          rem_n    = rem_s;
`endif
        end else begin
          result_n = prod_s[WIDTH-1:0];
          ovf_n    = mul_ovf;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Remember op kind and result signs while the iterative core runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div  <= 1'b0;
      neg     <= 1'b0;
`ifdef SEQ_ALU_REM_EN
      rem_neg <= 1'b0;
`endif
    end else if (start) begin
      is_div  <= (alu_op == ALU_DIV);
      neg     <= a[WIDTH-1] ^ b[WIDTH-1];
`ifdef SEQ_ALU_REM_EN
      rem_neg <= a[WIDTH-1];
`endif
    end
  end

  // Result and flag registers; they only change when a new result lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef SEQ_ALU_REM_EN
      rem         <= '0;
`endif
    end else if (load) begin
      result      <= result_n;
      zero        <= (result_n == '0);
      overflow    <= ovf_n;
      div_by_zero <= dbz_n;
`ifdef SEQ_ALU_REM_EN
      rem         <= rem_n;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus randomized
// ops compared against an integer-arithmetic reference model.
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        div_by_zero;
`ifdef SEQ_ALU_REM_EN
  logic [31:0] rem;
`endif

  int checks;
  int errors;

  seq_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alu_op     (alu_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .div_by_zero(div_by_zero)
`ifdef SEQ_ALU_REM_EN
    ,
    .rem        (rem)
`endif
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // Reference model in plain signed integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] xb,
                                output logic [31:0] r, output logic ov, output logic dz,
                                output logic [31:0] rm);
    longint sa;
    longint sb;
    longint t;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    r  = '0;
    ov = 1'b0;
    dz = 1'b0;
    rm = '0;
    case (op)
      3'd0: r = xa & xb;
      3'd1: r = xa | xb;
      3'd2: begin t = sa + sb; r = t[31:0]; ov = (t != longint'($signed(r))); end
      3'd6: begin t = sa - sb; r = t[31:0]; ov = (t != longint'($signed(r))); end
      3'd3: begin t = sa * sb; r = t[31:0]; ov = (t != longint'($signed(r))); end
      3'd4: begin
        if (xb == 32'd0) begin
          r = 32'hFFFF_FFFF; dz = 1'b1; rm = xa;
        end else if (xa == 32'h8000_0000 && xb == 32'hFFFF_FFFF) begin
          r = 32'h8000_0000; ov = 1'b1; rm = 32'd0;
        end else begin
          t = sa / sb; r = t[31:0];
          t = sa % sb; rm = t[31:0];
        end
      end
      3'd5: r = xb << xa[4:0];
      default: r = (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Issue one op (called #1 after a rising edge), wait for its result and check it.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] xb);
    logic [31:0] exp_res;
    logic [31:0] exp_rem;
    logic        exp_ovf;
    logic        exp_dbz;
    int          exp_lat;
    int          cycles;
    logic        ready_bad;
    model(op, xa, xb, exp_res, exp_ovf, exp_dbz, exp_rem);
    exp_lat = ((op == 3'd3) || (op == 3'd4 && xb != 32'd0)) ? 34 : 1;
    checkOutput($sformatf("in_ready_issue op%0d", op), in_ready, 1);
    alu_op   = op;
    a        = xa;
    b        = xb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    cycles    = 1;
    ready_bad = 1'b0;
    while (!out_valid && cycles < 200) begin
      if (in_ready) ready_bad = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput($sformatf("latency op%0d", op), cycles, exp_lat);
    if (exp_lat > 1) checkOutput($sformatf("busy_in_ready op%0d", op), ready_bad, 0);
    checkOutput($sformatf("out_valid op%0d", op), out_valid, 1);
    checkOutput($sformatf("result op%0d a=%h b=%h", op, xa, xb), result, exp_res);
    checkOutput($sformatf("zero op%0d", op), zero, exp_res == 32'd0);
    checkOutput($sformatf("overflow op%0d a=%h b=%h", op, xa, xb), overflow, exp_ovf);
    checkOutput($sformatf("div_by_zero op%0d", op), div_by_zero, exp_dbz);
`ifdef SEQ_ALU_REM_EN
    checkOutput($sformatf("rem op%0d a=%h b=%h", op, xa, xb), rem, exp_rem);
`endif
  endtask

  function automatic logic [31:0] rndVal();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  bb_op  [4];
  logic [31:0] bb_a   [4];
  logic [31:0] bb_b   [4];
  logic [31:0] bb_exp [4];
  logic [2:0]  rop;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    alu_op    = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset result", result, 0);
    checkOutput("reset zero", zero, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset div_by_zero", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases.
    applyStimulus(3'd2, 32'h7FFF_FFFF, 32'd1);
    applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd6);
    checkOutput("mul -7*6 const", result, 32'hFFFF_FFD6);
    applyStimulus(3'd3, 32'h0001_0000, 32'h0001_0000);
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div -7/2 const", result, 32'hFFFF_FFFD);
    applyStimulus(3'd4, 32'd5, 32'd0);
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(3'd6, 32'h8000_0000, 32'd1);
    applyStimulus(3'd5, 32'hFFFF_FFE3, 32'd1);

    // Back-to-back single-cycle ops with out_ready held high.
    bb_op[0] = 3'd0; bb_a[0] = 32'h0000_F0F0; bb_b[0] = 32'h0000_FF00; bb_exp[0] = 32'h0000_F000;
    bb_op[1] = 3'd1; bb_a[1] = 32'h0000_F0F0; bb_b[1] = 32'h0000_FF00; bb_exp[1] = 32'h0000_FFF0;
    bb_op[2] = 3'd7; bb_a[2] = 32'hFFFF_FFFF; bb_b[2] = 32'd1;         bb_exp[2] = 32'd1;
    bb_op[3] = 3'd5; bb_a[3] = 32'd4;         bb_b[3] = 32'd1;         bb_exp[3] = 32'h10;
    alu_op = bb_op[0]; a = bb_a[0]; b = bb_b[0]; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("b2b out_valid %0d", k), out_valid, 1);
      checkOutput($sformatf("b2b result %0d", k), result, bb_exp[k]);
      checkOutput($sformatf("b2b in_ready %0d", k), in_ready, 1);
      if (k < 3) begin
        alu_op = bb_op[k+1]; a = bb_a[k+1]; b = bb_b[k+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    checkOutput("b2b drain out_valid", out_valid, 0);

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    applyStimulus(3'd6, 32'd3, 32'd3);
    in_valid = 1'b1; alu_op = 3'd2; a = 32'd9; b = 32'd9;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("bp out_valid", out_valid, 1);
      checkOutput("bp result", result, 0);
      checkOutput("bp zero", zero, 1);
      checkOutput("bp in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp release out_valid", out_valid, 0);
    checkOutput("bp release in_ready", in_ready, 1);

    // Reset in the middle of a divide.
    alu_op = 3'd4; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", out_valid, 0);
    checkOutput("midreset result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) checkOutput("midreset partial result", out_valid, 0);
    end
    checkOutput("midreset in_ready", in_ready, 1);
    applyStimulus(3'd2, 32'd2, 32'd2);
    checkOutput("post-reset add const", result, 32'd4);

    // Randomized ops against the model.
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      applyStimulus(rop, rndVal(), rndVal());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the combinational ALU, with handshaked issue and result ports. Bitwise, add/sub, shift and SLT complete in one cycle. Signed MUL and DIV run iteratively: shift-add and restoring division, one bit per cycle. Sits between ID/EX operand latch and EX/MEM writeback; the pipeline stalls on in_ready low.

Parameters:
WIDTH, 32, operand/result width in bits (≥4, power of two)
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from a

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept
a  in  WIDTH  operand A (shift amount for SLL)
b  in  WIDTH  operand B
alu_op  in  3  0 AND, 1 OR, 2 ADD, 3 MUL, 4 DIV, 5 SLL (b<<a), 6 SUB, 7 SLT
out_valid  out  1  result registered and held
out_ready  in  1  consumer takes result
result  out  WIDTH  registered result
zero  out  1  result==0, registered with result
overflow  out  1  signed overflow (ADD/SUB/MUL/DIV)
div_by_zero  out  1  DIV with b==0

Behaviour:
- Reset: async, rst_n low → state IDLE, in_ready=1, out_valid=0, result=0, zero=0, overflow=0, div_by_zero=0. Mid-operation reset aborts; no partial result is ever emitted.
- States: IDLE, CALC, FIX, DONE. Accept = in_valid & in_ready.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept in DONE with out_ready high retires the old result and takes the new op on the same edge. There are no bubbles for single-cycle ops.
- Single-cycle ops: accept edge → DONE, flags registered; out_valid high one cycle after accept.
- ADD/SUB: WIDTH-bit wrap result. overflow = operand signs equal (B inverted for SUB) and result sign differs.
- SLL: result = b << a[SHAMT_W-1:0]; upper a bits ignored.
- SLT: signed compare; result = 1 if a<b else 0.
- AND/OR: overflow=0.
- MUL/DIV: accept edge latches |a|, |b|, result sign, counter=WIDTH-1 → CALC.
  - CALC: one iteration per cycle for WIDTH cycles. Counter reaching 0 → FIX.
  - FIX: apply sign → DONE. out_valid is high WIDTH+2 cycles after accept (34 for WIDTH=32).
  - in_ready=0 throughout CALC/FIX.
- MUL: result = low WIDTH bits of the signed 2·WIDTH product. overflow=1 when the product does not sign-fit in WIDTH bits.
- DIV: quotient truncates toward zero; remainder takes the sign of a.
  - b==0: skip CALC, DONE next cycle, result = all ones, div_by_zero=1, overflow=0.
  - a=most-negative, b=−1: full latency, result=most-negative, overflow=1.
- DONE: result/flags stable while out_valid & ~out_ready. out_ready high without new accept → IDLE.
- in_valid while busy is ignored (not queued); the source must hold it.
- zero is computed from the final registered result in every op.

Optional Feature:
SEQ_ALU_REM_EN:
- Defined: extra output port rem [WIDTH-1:0], registered and valid with out_valid. DIV gives the signed remainder; b==0 gives rem=a. All other ops give rem=0. Reset value 0.
- Undefined: port absent; remainder register removed.

Decomposition:
- Package alu_pkg: alu_op encodings (ALU_AND … ALU_SLT) as 3-bit localparams, state enum (S_IDLE, S_CALC, S_FIX, S_DONE), helper function for signed-overflow check.
- Sub-module seq_muldiv: iterative core. Takes start, magnitudes, and mul/div select. Returns done, product hi/lo, quotient, remainder.
- seq_alu holds handshake FSM, single-cycle datapath, sign fix, flag registers.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 → result 0x80000000, overflow=1, zero=0, out_valid cycle 1.
- MUL a=−7 (0xFFFFFFF9), b=6 → result 0xFFFFFFD6, overflow=0. in_ready low cycles 1–33, out_valid at cycle 34. MUL 0x10000×0x10000 → 0, overflow=1, zero=1.
- DIV a=−7, b=2 → result 0xFFFFFFFD (−3); rem=0xFFFFFFFF with SEQ_ALU_REM_EN. DIV 5/0 → 0xFFFFFFFF, div_by_zero=1, out_valid cycle 1. DIV 0x80000000/−1 → 0x80000000, overflow=1.
- Back-to-back: out_ready held 1, in_valid held with AND, OR, SLT(−1,1), SLL(a=4, b=1) → results 1/cycle. SLT gives 1, SLL gives 0x10. No gaps.
- Backpressure: out_ready=0 for 5 cycles after SUB 3−3 → result 0 and zero=1 held stable, in_ready=0. Release → IDLE next edge.
- rst_n pulsed low at cycle 10 of a DIV → out_valid 0 immediately, in_ready 1 after release, next ADD 2+2 → 4.
